// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer: FSM states, light patterns and BCD helpers.
package reaction_timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMING = 3'd1,
    FULL   = 3'd2,
    TIMING = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_e;

  localparam logic [7:0] LIGHTS_ALL_ON = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF    = 8'h00;

  // Four packed decimal digits of a value below 10000.
  function automatic logic [15:0] bin_to_bcd16(input int unsigned v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 32'd10);
    r[7:4]   = 4'((v / 32'd10) % 32'd10);
    r[11:8]  = 4'((v / 32'd100) % 32'd10);
    r[15:12] = 4'((v / 32'd1000) % 32'd10);
    return r;
  endfunction

  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_timer_rt_counter.sv
// Saturating tick counter; decimal (BCD) or binary increment chosen by REACTION_TIMER_BCD_OUT_EN.
module rt_counter
  import reaction_timer_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_d_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_inc;

`ifdef REACTION_TIMER_BCD_OUT_EN
  assign count_inc = bcd_inc16(count_q);
`else
  assign count_inc = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

  // Next count: clear wins, then a tick below the limit; the limit is sticky.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < LIMIT)) begin
      count_d = count_inc;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/reaction_timer.sv
// Measures ticks from lights-out to button press and flags jump starts.
// Define REACTION_TIMER_BCD_OUT_EN for a four-digit BCD result (WIDTH must be 16).
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_T = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       lights,
  input  logic             btn,
  input  logic             clr,
  output logic [WIDTH-1:0] rt,
  output logic             valid,
  output logic             false_start,
  output logic             busy
);

`ifdef REACTION_TIMER_BCD_OUT_EN
  localparam logic [WIDTH-1:0] LIMIT = bin_to_bcd16(int unsigned'(MAX_T));
`else
  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_T);
`endif

  state_e           state_q, state_d;
  logic             btn_q;
  logic             press;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             busy_d;
  logic [WIDTH-1:0] cnt_unused;
  logic [WIDTH-1:0] cnt_d;

  assign press = btn & ~btn_q;

  // Counter stays at zero outside TIMING so it starts fresh at lights-out.
  rt_counter #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q != TIMING),
    .inc_i     ((state_q == TIMING) && en),
    .count_o   (cnt_unused),
    .count_d_o (cnt_d)
  );

  // Sequencing FSM and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    rt_d    = rt_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    if (clr) begin
      state_d = IDLE;
      rt_d    = '0;
      valid_d = 1'b0;
      fs_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lights != LIGHTS_OFF) state_d = ARMING;
          else                      state_d = IDLE;
        end
        ARMING: begin
          if (press)                         state_d = FAULT;
          else if (lights == LIGHTS_ALL_ON)  state_d = FULL;
          else if (lights == LIGHTS_OFF)     state_d = IDLE;
          else                               state_d = ARMING;
        end
        FULL: begin
          if (press)                      state_d = FAULT;
          else if (lights == LIGHTS_OFF)  state_d = TIMING;
          else                            state_d = FULL;
        end
        TIMING: begin
          if (press) begin
            state_d = DONE;
            rt_d    = cnt_d;
            valid_d = 1'b1;
          end else if (cnt_d == LIMIT) begin
            state_d = DONE;
            rt_d    = LIMIT;
            valid_d = 1'b1;
          end else begin
            state_d = TIMING;
          end
        end
        DONE, FAULT: begin
          if (lights != LIGHTS_OFF) begin
            state_d = ARMING;
            rt_d    = '0;
            valid_d = 1'b0;
            fs_d    = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
          rt_d    = '0;
          valid_d = 1'b0;
          fs_d    = 1'b0;
        end
      endcase
      // Entering FAULT from ARMING or FULL raises the flag and drops any result.
      if ((state_d == FAULT) && (state_q != FAULT)) begin
        fs_d    = 1'b1;
        rt_d    = '0;
        valid_d = 1'b0;
      end else begin
        fs_d = fs_d;
      end
    end
    busy_d = (state_d == ARMING) || (state_d == FULL) || (state_d == TIMING);
  end

  // State, button history and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      btn_q   <= 1'b0;
      rt_q    <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      busy    <= busy_d;
    end
  end

  assign rt          = rt_q;
  assign valid       = valid_q;
  assign false_start = fs_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised and directed bench for reaction_timer against a cycle-level behavioural model.
module tb_reaction_timer;

  localparam int WIDTH = 16;
  localparam int MAX_T = 9999;

  logic             clk = 1'b0;
  logic             rst, en, btn, clr;
  logic [7:0]       lights;
  logic [WIDTH-1:0] rt;
  logic             valid, false_start, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model phases of a start sequence, as the player sees it.
  localparam int PH_WAIT = 0, PH_LIGHTING = 1, PH_ALLON = 2, PH_RUNNING = 3,
                 PH_RESULT = 4, PH_JUMPED = 5;
  int m_phase, m_ticks, m_rt;
  bit m_valid, m_fs, m_btn_prev;

  reaction_timer #(.WIDTH(WIDTH), .MAX_T(MAX_T)) dut (
    .clk(clk), .rst(rst), .en(en), .lights(lights), .btn(btn), .clr(clr),
    .rt(rt), .valid(valid), .false_start(false_start), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] enc(input int v);
`ifdef REACTION_TIMER_BCD_OUT_EN
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
    return WIDTH'(v);
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_result();
    m_rt = 0; m_valid = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_step();
    bit pressed;
    pressed = btn && !m_btn_prev;
    if (rst) begin
      m_phase = PH_WAIT; m_ticks = 0; m_btn_prev = 1'b0;
      clear_result();
      return;
    end
    if (clr) begin
      m_phase = PH_WAIT;
      clear_result();
    end else begin
      case (m_phase)
        PH_WAIT:     if (lights != 8'h00) m_phase = PH_LIGHTING;
        PH_LIGHTING: if (pressed) begin m_phase = PH_JUMPED; clear_result(); m_fs = 1'b1; end
                     else if (lights == 8'hFF) m_phase = PH_ALLON;
                     else if (lights == 8'h00) m_phase = PH_WAIT;
        PH_ALLON:    if (pressed) begin m_phase = PH_JUMPED; clear_result(); m_fs = 1'b1; end
                     else if (lights == 8'h00) begin m_phase = PH_RUNNING; m_ticks = 0; end
        PH_RUNNING: begin
          if (en && m_ticks < MAX_T) m_ticks++;
          if (pressed || m_ticks == MAX_T) begin
            m_phase = PH_RESULT; m_rt = m_ticks; m_valid = 1'b1;
          end
        end
        default:     if (lights != 8'h00) begin m_phase = PH_LIGHTING; clear_result(); end
      endcase
    end
    m_btn_prev = btn;
  endtask

  task automatic cycle();
    bit exp_busy;
    @(posedge clk);
    model_step();
    #1;
    exp_busy = (m_phase == PH_LIGHTING) || (m_phase == PH_ALLON) || (m_phase == PH_RUNNING);
    check_eq("rt", 32'(rt), 32'(enc(m_rt)));
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("false_start", 32'(false_start), 32'(m_fs));
    check_eq("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic lights_up(input int steps, input bit b);
    logic [8:0] p;
    for (int i = 0; i < steps; i++) begin
      p = (9'd1 << (i + 1)) - 9'd1;
      lights = p[7:0]; btn = b; en = 1'b0; clr = 1'b0;
      cycle();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1; cycle();
      en = 1'b0;
      if ($urandom_range(0, 1) == 1) cycle();
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cycle(); clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; btn = 1'b0; clr = 1'b0; lights = 8'h00;
    cycle(); cycle();
    check_eq("reset_rt", 32'(rt), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cycle();

    // Normal run: 237 ticks after lights-out.
    lights_up(8, 1'b0);
    lights = 8'h00; cycle();
    ticks(237);
    btn = 1'b1; cycle();
    check_eq("normal_rt", 32'(rt), 32'(enc(237)));
    check_eq("normal_valid", 32'(valid), 32'd1);
    check_eq("normal_fs", 32'(false_start), 32'd0);
    btn = 1'b0; cycle();
    pulse_clr();
    check_eq("clr_valid", 32'(valid), 32'd0);
    check_eq("clr_busy", 32'(busy), 32'd0);

    // Jump start at 1F; lights-out afterwards must not start timing.
    lights_up(5, 1'b0);
    btn = 1'b1; cycle();
    check_eq("jump_fs", 32'(false_start), 32'd1);
    check_eq("jump_valid", 32'(valid), 32'd0);
    check_eq("jump_rt", 32'(rt), 32'd0);
    lights = 8'h00; cycle();
    ticks(5);
    check_eq("jump_no_timing", 32'(busy), 32'd0);
    check_eq("jump_fs_hold", 32'(false_start), 32'd1);
    btn = 1'b0; pulse_clr();

    // Press in the same cycle as lights-out.
    lights_up(8, 1'b0);
    lights = 8'h00; btn = 1'b1; cycle();
    check_eq("simul_fs", 32'(false_start), 32'd1);
    btn = 1'b0; pulse_clr();

    // Tick and press together at count 41.
    lights_up(8, 1'b0);
    lights = 8'h00; cycle();
    ticks(41);
    en = 1'b1; btn = 1'b1; cycle();
    check_eq("tick_press_rt", 32'(rt), 32'(enc(42)));
    en = 1'b0; btn = 1'b0; pulse_clr();

    // Saturation with no press.
    lights_up(8, 1'b0);
    lights = 8'h00; cycle();
    en = 1'b1;
    for (int i = 0; i < 10000; i++) cycle();
    en = 1'b0;
    check_eq("sat_rt", 32'(rt), 32'(enc(9999)));
    check_eq("sat_valid", 32'(valid), 32'd1);
    pulse_clr();

    // Button held through lights-out is not a press.
    lights_up(8, 1'b1);
    lights = 8'h00; cycle(); cycle(); cycle();
    check_eq("held_fs", 32'(false_start), 32'd0);
    check_eq("held_busy", 32'(busy), 32'd1);
    btn = 1'b0; cycle();
    ticks(50);
    btn = 1'b1; cycle();
    check_eq("held_rt", 32'(rt), 32'(enc(50)));
    btn = 1'b0; pulse_clr();

    // Reset mid-measurement.
    lights_up(8, 1'b0);
    lights = 8'h00; cycle();
    ticks(20);
    rst = 1'b1; cycle();
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_valid", 32'(valid), 32'd0);
    rst = 1'b0; cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [8:0] p;
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 49) == 0);
      en  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      r = $urandom_range(0, 9);
      if (r == 4 || r == 5) lights = 8'h00;
      else if (r == 6 || r == 7) lights = 8'hFF;
      else if (r == 8) begin p = {lights, 1'b1}; lights = p[7:0]; end
      else if (r == 9) lights = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
